fig_instruction_prefetch: RTL

- Instruction fetch stage directly downstream of the R15 program counter.
- Issues ROM byte reads at {pbr, pc} and buffers returned opcodes in a 2-entry queue for the decoder.
- Pulses pcen back to the program counter once per accepted fetch.
- Discards in-flight and queued opcodes when a branch or loop reloads R15.

---
 rtl/fig_instruction_prefetch_if.sv | 21 ++
 rtl/fig_instruction_prefetch.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fig_instruction_prefetch_if.sv
// ROM read bus and decoder opcode handshake for fig_instruction_prefetch.
// master: the prefetch stage; slave: the ROM / decoder side.
interface fig_instruction_prefetch_if;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic        opcode_ready;

  modport master (
    output rom_req, rom_addr, opcode, opcode_valid,
    input  rom_ack, rom_data, opcode_ready
  );

  modport slave (
    input  rom_req, rom_addr, opcode, opcode_valid,
    output rom_ack, rom_data, opcode_ready
  );
endinterface

// File: rtl/fig_instruction_prefetch.sv
// Instruction prefetch stage behind R15: issues byte reads at {pbr, pc},
// queues up to two opcodes for the decoder, pulses pcen once per accepted
// fetch and discards in-flight/queued bytes when R15 is reloaded (flush).
// Optional macro IFETCH_TIMEOUT_EN adds a bus watchdog with a sticky
// fetch_error; without it the bus waits indefinitely and fetch_error is 0.
module fig_instruction_prefetch #(
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 pc,
  input  logic [7:0]                  pbr,
  input  logic                        cchld,
  input  logic                        flush,
  output logic                        pcen,
  output logic                        fetch_error,
  fig_instruction_prefetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, INC, DRAIN} state_t;

  state_t      state, state_n;
  logic [1:0]  count;
  logic [7:0]  q0, q1;
  logic        busy;
  logic        push, pop, clear;
  logic        timeout;
  logic        halt;
  logic        start;

  assign busy  = (state == REQ) || (state == DRAIN);
  assign push  = (state == REQ) && bus.rom_ack && !flush && !timeout;
  assign pop   = (count != 2'd0) && bus.opcode_ready;
  assign clear = flush || timeout;
  assign start = (state == IDLE) && (state_n == REQ);

  // The request line is exactly "a bus transaction is open".
  assign bus.rom_req      = busy;
  assign bus.opcode       = q0;
  assign bus.opcode_valid = (count != 2'd0);
  // R15 gives a reload priority over pcen, so INC pulses even under flush.
  assign pcen             = (state == INC);

`ifdef IFETCH_TIMEOUT_EN
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TCW-1:0] tcnt;
  logic           err;

  assign timeout     = busy && !bus.rom_ack && (tcnt == TCW'(TIMEOUT - 1));
  assign halt        = err;
  assign fetch_error = err;

  // Watchdog: counts cycles of an open transaction; error is sticky.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (!busy || bus.rom_ack || timeout) tcnt <= '0;
      else                                 tcnt <= tcnt + TCW'(1);
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign halt        = 1'b0;
  // No watchdog compiled in; TIMEOUT has no effect and the flag reads 0.
  assign fetch_error = (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!cchld && !flush && !halt && (count < 2'(QDEPTH)))
                 state_n = REQ;
      REQ:     if (bus.rom_ack) state_n = flush ? IDLE : INC;
               else if (flush)  state_n = DRAIN;
      DRAIN:   if (bus.rom_ack) state_n = IDLE;
      INC:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end

  // Fetch address is captured once when the request opens and held.
  always_ff @(posedge clk) begin
    if (!reset)     bus.rom_addr <= 24'h0;
    else if (start) bus.rom_addr <= {pbr, pc};
  end

  // Two-entry opcode FIFO with registered head; clear beats push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      q0    <= 8'h0;
      q1    <= 8'h0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) q0 <= bus.rom_data;
          else               q1 <= bus.rom_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q0 <= bus.rom_data;
          end else begin
            q0 <= q1;
            q1 <= bus.rom_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
